// File: rtl/matmul_seq_ctrl_if.sv
// Operand/result bundle for the matrix-multiply sequencer.
// The master side drives the request and operands; the slave side returns results and status.
interface matmul_seq_ctrl_if #(
    parameter int unsigned mat_size = 2,
    parameter int unsigned dat_size = 8
);
    logic                start;
    logic [dat_size-1:0] mat_A [mat_size][mat_size];
    logic [dat_size-1:0] mat_B [mat_size][mat_size];
    logic [dat_size-1:0] mat_C [mat_size][mat_size];
    logic                busy;
    logic                done;

    modport master (output start, mat_A, mat_B, input mat_C, busy, done);
    modport slave  (input start, mat_A, mat_B, output mat_C, busy, done);
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Clocked i/j/k sequencer for an N x N matrix multiply over one shared MAC.
// Snapshots A/B on start, writes C row-major, and pulses done for one cycle at the end.
module matmul_seq_ctrl #(
    parameter int unsigned mat_size = 2,
    parameter int unsigned dat_size = 8
) (
    input  logic               clk,
    input  logic               rst,
    matmul_seq_ctrl_if.slave   bus
);
    localparam int unsigned cw = (mat_size > 1) ? $clog2(mat_size) : 1;
    localparam int unsigned aw = 2 * dat_size + $clog2(mat_size);
    localparam logic [cw-1:0] last = cw'(mat_size - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                load_c;
    logic                last_elem_c;
    logic [cw-1:0]       i_q, j_q, k_q;
    logic [aw-1:0]       acc_q;
    logic [aw-1:0]       sum_c;
    logic [dat_size-1:0] a_q [mat_size][mat_size];
    logic [dat_size-1:0] b_q [mat_size][mat_size];
    logic [dat_size-1:0] c_q [mat_size][mat_size];

    assign last_elem_c = (i_q == last) && (j_q == last) && (k_q == last);
    assign sum_c       = acc_q + aw'(a_q[i_q][k_q]) * aw'(b_q[k_q][j_q]);

    // State and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_nxt = state;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        load_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = MAC;
                    busy_nxt  = 1'b1;
                    load_c    = 1'b1;
                end
            end
            MAC: begin
                if (last_elem_c) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Operand snapshot, loop counters, accumulator and result array
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            c_q   <= '{default: '0};
        end else if (load_c) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            a_q   <= bus.mat_A;
            b_q   <= bus.mat_B;
        end else if (state == MAC) begin
            if (k_q != last) begin
                acc_q <= sum_c;
                k_q   <= k_q + 1'b1;
            end else begin
                // Element complete: keep only the low dat_size bits
                c_q[i_q][j_q] <= sum_c[dat_size-1:0];
                acc_q         <= '0;
                k_q           <= '0;
                if (j_q != last) begin
                    j_q <= j_q + 1'b1;
                end else if (i_q != last) begin
                    j_q <= '0;
                    i_q <= i_q + 1'b1;
                end
            end
        end
    end

    assign bus.mat_C = c_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: 2x2 vector table plus sequences for
// operand stability, ignored restarts, back-to-back jobs, mid-job reset and a 3x3 build.
module tb_matmul_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_seq_ctrl_if #(.mat_size(2), .dat_size(8)) bus2 ();
    matmul_seq_ctrl_if #(.mat_size(3), .dat_size(8)) bus3 ();

    matmul_seq_ctrl #(.mat_size(2), .dat_size(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    matmul_seq_ctrl #(.mat_size(3), .dat_size(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef logic [7:0] m2_t [2][2];
    typedef logic [7:0] m3_t [3][3];
    typedef struct {
        string name;
        m2_t   a;
        m2_t   b;
        m2_t   c;
    } vec_t;

    vec_t vecs[4];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_c2(input string tag, input m2_t exp);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                check($sformatf("%s C[%0d][%0d]", tag, r, c), int'(bus2.mat_C[r][c]), int'(exp[r][c]));
    endtask

    // One 2x2 job from IDLE; optionally zero live A two cycles after start
    task automatic run2(input string tag, input m2_t a, input m2_t b, input m2_t expc, input bit zero_a);
        int  cnt;
        m2_t z;
        z = '{'{8'd0, 8'd0}, '{8'd0, 8'd0}};
        @(negedge clk);
        bus2.mat_A = a;
        bus2.mat_B = b;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        check({tag, " busy after start"}, int'(bus2.busy), 1);
        check({tag, " done after start"}, int'(bus2.done), 0);
        cnt = 0;
        while (!bus2.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (zero_a && cnt == 2) bus2.mat_A = z;
        end
        check({tag, " latency"}, cnt, 8);
        check({tag, " busy during done"}, int'(bus2.busy), 0);
        check_c2(tag, expc);
        @(negedge clk);
        check({tag, " done width"}, int'(bus2.done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  seen;
        int  d[3];
        m2_t zero2;
        m3_t a3, i3, z3;

        vecs[0] = '{"basic",  '{'{8'd1, 8'd2}, '{8'd3, 8'd4}},     '{'{8'd5, 8'd6}, '{8'd7, 8'd8}},
                                '{'{8'd19, 8'd22}, '{8'd43, 8'd50}}};
        vecs[1] = '{"ovf",    '{'{8'hFF, 8'hFF}, '{8'hFF, 8'hFF}}, '{'{8'hFF, 8'hFF}, '{8'hFF, 8'hFF}},
                                '{'{8'h02, 8'h02}, '{8'h02, 8'h02}}};
        vecs[2] = '{"ident",  '{'{8'd1, 8'd0}, '{8'd0, 8'd1}},     '{'{8'd9, 8'd8}, '{8'd7, 8'd6}},
                                '{'{8'd9, 8'd8}, '{8'd7, 8'd6}}};
        vecs[3] = '{"mixed",  '{'{8'd2, 8'd0}, '{8'd1, 8'd3}},     '{'{8'd4, 8'd5}, '{8'd6, 8'd7}},
                                '{'{8'd8, 8'd10}, '{8'd22, 8'd26}}};
        zero2 = '{'{8'd0, 8'd0}, '{8'd0, 8'd0}};
        a3    = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
        i3    = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'd1, 8'd0}, '{8'd0, 8'd0, 8'd1}};
        z3    = '{default: 8'd0};

        rst = 1'b1;
        bus2.start = 1'b0; bus2.mat_A = zero2; bus2.mat_B = zero2;
        bus3.start = 1'b0; bus3.mat_A = z3;    bus3.mat_B = z3;
        repeat (2) @(negedge clk);
        check("reset busy", int'(bus2.busy), 0);
        check("reset done", int'(bus2.done), 0);
        check_c2("reset", zero2);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", int'(bus2.busy), 0);

        for (int v = 0; v < 4; v++)
            run2(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].c, 1'b0);

        // Live A cleared mid-job must not affect the snapshot
        run2("stable", vecs[0].a, vecs[0].b, vecs[0].c, 1'b1);
        bus2.mat_A = vecs[0].a;

        // Start pulses during MAC and DONE are ignored
        @(negedge clk);
        bus2.mat_A = vecs[3].a; bus2.mat_B = vecs[3].b; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        cnt = 0;
        while (!bus2.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
            bus2.start = (cnt == 3);
        end
        check("repulse latency", cnt, 8);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        seen = 0;
        for (int t = 0; t < 15; t++) begin
            if (bus2.busy || bus2.done) seen++;
            @(negedge clk);
        end
        check("repulse extra activity", seen, 0);
        check_c2("repulse", vecs[3].c);

        // Start held high: jobs every N^3+2 cycles
        bus2.mat_A = vecs[0].a; bus2.mat_B = vecs[0].b; bus2.start = 1'b1;
        cnt = 0; seen = 0;
        while (seen < 3 && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (bus2.done) begin
                d[seen] = cnt;
                seen++;
            end
        end
        bus2.start = 1'b0;
        check("held pulses", seen, 3);
        check("held period 1", d[1] - d[0], 10);
        check("held period 2", d[2] - d[1], 10);
        check_c2("held", vecs[0].c);
        repeat (2) @(negedge clk);

        // Reset in the middle of a job clears everything
        bus2.mat_A = vecs[3].a; bus2.mat_B = vecs[3].b; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", int'(bus2.busy), 0);
        check("midreset done", int'(bus2.done), 0);
        check_c2("midreset", zero2);
        @(negedge clk);
        check("midreset stays idle", int'(bus2.busy), 0);
        run2("after reset", vecs[0].a, vecs[0].b, vecs[0].c, 1'b0);

        // 3x3 build: C = A * I, row-major write order
        @(negedge clk);
        bus3.mat_A = a3; bus3.mat_B = i3; bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        check("n3 busy after start", int'(bus3.busy), 1);
        cnt = 0;
        while (!bus3.done && cnt < 80) begin
            @(negedge clk);
            cnt++;
            if (cnt == 3) begin
                check("n3 C[0][0] first", int'(bus3.mat_C[0][0]), 1);
                check("n3 C[0][1] not yet", int'(bus3.mat_C[0][1]), 0);
            end
        end
        check("n3 latency", cnt, 27);
        check("n3 busy during done", int'(bus3.busy), 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("n3 C[%0d][%0d]", r, c), int'(bus3.mat_C[r][c]), int'(a3[r][c]));
        @(negedge clk);
        check("n3 done width", int'(bus3.done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
